// File: rtl/bcd_display_driver.sv
// Two-digit multiplexed seven-segment driver for the BCD adder result.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank a zero tens digit).
module bcd_display_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] s1,
  input  logic [3:0] s0,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err
);

  // load is a one-cycle capture strobe with no ready: every edge with load=1
  // captures s1/s0, so back-to-back strobes simply overwrite (last one wins).

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_ZERO   = 7'b0111111;
  localparam logic [6:0] SEG_ERR    = 7'b1111001;
  localparam logic [6:0] SEG_BLANK  = 7'b0000000;
  localparam logic [1:0] AN_ONES    = 2'b01;
  localparam logic [1:0] AN_TENS    = 2'b10;
  localparam logic [6:0] SEG_RST    = (ACTIVE_LOW != 0) ? ~SEG_ZERO : SEG_ZERO;
  localparam logic [1:0] AN_RST     = (ACTIVE_LOW != 0) ? ~AN_ONES : AN_ONES;

  logic [3:0]       d1_q, d1_d;
  logic [3:0]       d0_q, d0_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;

  logic             wrap;
  logic [3:0]       digit;
  logic [6:0]       seg_raw;
  logic [1:0]       an_raw;

  function automatic logic [6:0] decode_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = SEG_ERR;
    endcase
    return s;
  endfunction

  // Capture path: the held pair and its validity flag move together.
  always_comb begin
    d1_d  = d1_q;
    d0_d  = d0_q;
    err_d = err_q;
    if (load) begin
      d1_d  = s1;
      d0_d  = s0;
      err_d = (s1 > 4'd9) || (s0 > 4'd9);
    end
  end

  // Scan timing is free-running and independent of load.
  always_comb begin
    wrap  = (cnt_q == CNT_MAX);
    cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    sel_d = wrap ? ~sel_q : sel_q;
  end

  // Output path uses the currently held values, so new data shows one edge after capture.
  always_comb begin
    digit   = sel_q ? d1_q : d0_q;
    seg_raw = decode_digit(digit);
`ifdef LEADING_ZERO_BLANK_EN
    if (sel_q && (d1_q == 4'd0) && !err_q) begin
      seg_raw = SEG_BLANK;
    end
`endif
    an_raw = sel_q ? AN_TENS : AN_ONES;
    seg_d  = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    an_d   = (ACTIVE_LOW != 0) ? ~an_raw : an_raw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d1_q  <= 4'd0;
      d0_q  <= 4'd0;
      err_q <= 1'b0;
      cnt_q <= '0;
      sel_q <= 1'b0;
      seg_q <= SEG_RST;
      an_q  <= AN_RST;
    end else begin
      d1_q  <= d1_d;
      d0_q  <= d0_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign err = err_q;

endmodule

// File: doc/bcd_display_driver.md
# bcd_display_driver

Downstream consumer of the two-digit BCD adder result (tens digit S1, ones digit S0). Captures a digit pair on a load strobe, validates it, and drives a two-digit multiplexed seven-segment display with a fixed refresh cadence. Sits between the BCD adder and the board's display pins.

## Interface

Parameters:
- REFRESH_DIV, default 50000: clock cycles each digit is displayed before the scan switches; legal range ≥ 2.
- ACTIVE_LOW, default 1: 1 means seg and an are driven active-low; 0 means active-high.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  capture strobe; s1/s0 are sampled on any rising edge where load=1.
- s1  input  4  tens BCD digit from the adder.
- s0  input  4  ones BCD digit from the adder.
- seg  output  7  segment drive {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW.
- an  output  2  digit enables: an[0] is ones, an[1] is tens; one-hot asserted, polarity per ACTIVE_LOW.
- err  output  1  high while the held pair contains a digit > 9.

## Operation

- Held registers: d1, d0 (4 bits each) and err.
  - On load: d1<=s1, d0<=s0, err<=(s1>9)|(s0>9).
  - With no load, all three hold their values.
- Refresh counter cnt runs 0..REFRESH_DIV-1 and wraps to 0.
  - At cnt==REFRESH_DIV-1, the scan bit sel toggles (0=ones, 1=tens).
  - load does not affect cnt or sel.
- Digit selection: sel=0 selects d0; sel=1 selects d1.
- Decode of the selected digit to {g..a}, before polarity:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - 10..15 = 'E' = 1111001
- Each digit decodes independently: invalid digit shows 'E' and the other valid digit shows normally.
- An enable is asserted only for the selected digit. The other enable is deasserted.
- When ACTIVE_LOW=1, both seg and an are bitwise inverted at the output register.
- Reset state: d1=d0=0, err=0, cnt=0, sel=0.
- Output reset values:
  - ACTIVE_LOW=1: seg=7'b1000000 ('0' on ones), an=2'b10.
  - ACTIVE_LOW=0: seg=7'b0111111, an=2'b01.
- Reset asserted mid-scan or mid-load overrides everything. The state above takes effect at that edge, and any load on the same edge is ignored.

## Timing

- seg and an are registered and computed from the current d1/d0/err/sel.
  - Load at edge N updates d* and err at edge N.
  - seg/an show the new value at edge N+1.
- err is registered with d* and is valid at edge N, the same edge as capture.
- sel toggles on the edge where cnt==REFRESH_DIV-1; an/seg follow one edge later.
  - Each digit is enabled for exactly REFRESH_DIV consecutive cycles.
  - The only exception is the first ones period after reset, which is REFRESH_DIV+1 cycles.
- Load coinciding with a sel toggle: both take effect on that edge. The next output uses the new data and the new sel.
- Back-to-back loads: each is captured and the last one wins. There is no busy state and no backpressure.

## Configuration

- Macro LEADING_ZERO_BLANK_EN.
- Defined: when d1==0 and err==0, the tens slot drives seg all-off (7'b0000000 before polarity) while an[1] is still asserted. Scan timing is unchanged.
- Undefined: the tens slot always shows its decoded digit, so d1==0 shows '0'.

## Test plan

Benches use REFRESH_DIV=4 and ACTIVE_LOW=0.

- Reset held 2 cycles, then released: seg=0111111, an=01 and err=0. an flips to 10 after 5 cycles, then alternates every 4 cycles.
- load with s1=4, s0=2: err=0. Ones slot seg=1011011 and tens slot seg=1100110 on the following scan periods.
- load with s1=0, s0=7, with LEADING_ZERO_BLANK_EN defined: tens slot seg=0000000 with an=10. With the macro undefined, tens slot seg=0111111.
- load with s1=12, s0=3: err=1 on the capture edge, tens slot seg=1111001 and ones slot seg=1001111. A later load with s1=1, s0=9 clears err.
- load pulsed on the same edge as the sel toggle: the next output shows the new digit for the new slot, and the scan period length is unchanged.
- reset asserted mid-period together with load=1, s1=9, s0=9: d1=d0=0 and err=0, outputs return to the reset values, and the scan restarts from the ones slot.
